// File: rtl/shift_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Contents: data/amount/counter widths, the shift opcode enum, the response
// buffer state enum, the command payload struct and the opcode-to-shift-unit
// control decode used by the top level.
package shift_pkg;

   localparam int unsigned SHIFT_W = 8;
   localparam int unsigned AMT_W   = 3;
   localparam int unsigned N_W     = 4;    // shift-unit amount width, holds 0..8
   localparam int unsigned CNT_W   = 16;

   typedef enum logic [1:0] {
      SRL = 2'b00,
      SRA = 2'b01,
      SLL = 2'b10,
      ROR = 2'b11
   } shift_op_t;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

   typedef struct packed {
      shift_op_t          op;
      logic [AMT_W-1:0]   amt;
      logic [SHIFT_W-1:0] data;
   } shift_cmd_t;

   typedef struct packed {
      logic ar;
      logic lr;
      logic rot;
   } shift_ctl_t;

   // Opcode to shift-unit control lines.
   function automatic shift_ctl_t decode_op(input shift_op_t op);
      shift_ctl_t ctl;
      ctl = '{ar: 1'b0, lr: 1'b0, rot: 1'b0};
      unique case (op)
         SRL: ctl = '{ar: 1'b0, lr: 1'b0, rot: 1'b0};
         SRA: ctl = '{ar: 1'b1, lr: 1'b0, rot: 1'b0};
         SLL: ctl = '{ar: 1'b0, lr: 1'b1, rot: 1'b0};
         ROR: ctl = '{ar: 1'b0, lr: 1'b0, rot: 1'b1};
         default: ctl = '{ar: 1'b0, lr: 1'b0, rot: 1'b0};
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational 8-bit shifter built on a 16-bit funnel right-shift of {hi, lo}.
// Ports:
//   i    operand
//   n    shift amount (0..7 from the arbiter)
//   ar   arithmetic right: hi filled with the operand sign bit
//   lr   left shift: {i, 0} funnelled right by 8-n
//   rot  rotate right: {i, i} funnelled right by n
//   y_c  result (combinational)
// With none of ar/lr/rot set the unit performs a logical right shift.
module shift_unit
   import shift_pkg::*;
(
   input  logic [SHIFT_W-1:0] i,
   input  logic [N_W-1:0]     n,
   input  logic               ar,
   input  logic               lr,
   input  logic               rot,
   output logic [SHIFT_W-1:0] y_c
);

   localparam logic [N_W-1:0] N_FULL = N_W'(SHIFT_W);

   logic [SHIFT_W-1:0] hi;
   logic [SHIFT_W-1:0] lo;
   logic [N_W-1:0]     sh;

   // Pick the funnel halves and distance, then keep the low byte.
   always_comb begin
      hi = '0;
      lo = i;
      sh = n;
      if (rot) begin
         hi = i;
      end else if (lr) begin
         // n=0 gives sh=8, which returns the operand unchanged.
         hi = i;
         lo = '0;
         sh = N_FULL - n;
      end else if (ar) begin
         hi = {SHIFT_W{i[SHIFT_W-1]}};
      end
      y_c = SHIFT_W'({hi, lo} >> sh);
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between two requesters.
// Accepted commands are shifted combinationally and captured in a one-entry
// response buffer tagged with the requester id.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         command handshake for requester N (0/1)
//   reqN_data/amt/op         operand, shift amount, opcode
//   rsp_valid/ready          response buffer handshake
//   rsp_data, rsp_id         shift result and issuing requester
//   grant_cnt0/1             accepted-command counters (wrap at 0xFFFF)
module shift_arbiter
   import shift_pkg::*;
(
   input  logic               clk,
   input  logic               rst,

   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [SHIFT_W-1:0] req0_data,
   input  logic [AMT_W-1:0]   req0_amt,
   input  shift_op_t          req0_op,

   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [SHIFT_W-1:0] req1_data,
   input  logic [AMT_W-1:0]   req1_amt,
   input  shift_op_t          req1_op,

   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [SHIFT_W-1:0] rsp_data,
   output logic               rsp_id,

   output logic [CNT_W-1:0]   grant_cnt0,
   output logic [CNT_W-1:0]   grant_cnt1
);

   buf_state_t         buf_state;
   logic               last_grant;

   logic               accept;
   logic               grant0;
   logic               grant1;
   logic               hs;
   shift_cmd_t         cmd_sel;
   shift_ctl_t         ctl;
   logic [SHIFT_W-1:0] shift_res_c;

   assign rsp_valid = (buf_state == BUF_FULL);

   // Buffer can take a new command when empty or draining this cycle.
   assign accept = (buf_state == BUF_EMPTY) || rsp_ready;

   // A lone valid requester wins; on a tie the one not granted last wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && (!req1_valid || last_grant)) begin
         grant0 = 1'b1;
      end else if (req1_valid) begin
         grant1 = 1'b1;
      end
   end

   assign req0_ready = !rst && accept && grant0;
   assign req1_ready = !rst && accept && grant1;
   assign hs         = req0_ready || req1_ready;

   // Steer the granted command into the shared shifter.
   always_comb begin
      cmd_sel = '{op: req0_op, amt: req0_amt, data: req0_data};
      if (grant1) begin
         cmd_sel = '{op: req1_op, amt: req1_amt, data: req1_data};
      end
      ctl = decode_op(cmd_sel.op);
   end

   shift_unit u_shift_unit (
      .i   (cmd_sel.data),
      .n   (N_W'(cmd_sel.amt)),
      .ar  (ctl.ar),
      .lr  (ctl.lr),
      .rot (ctl.rot),
      .y_c (shift_res_c)
   );

   // Response buffer, round-robin pointer and grant counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_state  <= BUF_EMPTY;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (hs) begin
            // Loads also cover a simultaneous drain: no bubble.
            buf_state  <= BUF_FULL;
            rsp_data   <= shift_res_c;
            rsp_id     <= grant1;
            last_grant <= grant1;
            if (grant1) begin
               grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end else begin
               grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            end
         end else if (rsp_ready) begin
            buf_state <= BUF_EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomised, scoreboard-checked bench for shift_arbiter.
module tb_shift_arbiter;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [7:0]  req0_data, req1_data;
   logic [2:0]  req0_amt, req1_amt;
   shift_op_t   req0_op, req1_op;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic [15:0] grant_cnt0, grant_cnt1;

   always #5 clk = ~clk;

   shift_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req0_amt   (req0_amt),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .req1_amt   (req1_amt),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   typedef struct {
      logic [7:0] data;
      logic       id;
      int         stamp;
   } exp_t;

   exp_t        q[$];
   int          cycle = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   // Reference model state.
   logic        m_last;
   logic [15:0] m_cnt0, m_cnt1;
   logic        m_acc, m_g0, m_g1;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
   endtask

   // Shift semantics from plain integer arithmetic.
   function automatic logic [7:0] ref_shift(input int d, input int a, input int op);
      int p, s, r;
      p = 1 << a;
      case (op)
         0: r = d / p;
         1: begin
            s = (d >= 128) ? d - 256 : d;
            r = (s >= 0) ? s / p : -((-s + p - 1) / p);
         end
         2: r = (d * p) % 256;
         default: r = d / p + (d * (256 / p)) % 256;
      endcase
      return 8'(r & 255);
   endfunction

   // Stimulus side: predict readies, push expected responses for handshakes.
   always @(negedge clk) begin
      if (rst) begin
         check("req0_ready_in_reset", req0_ready, 0);
         check("req1_ready_in_reset", req1_ready, 0);
         q.delete();
         m_last = 1'b1;
         m_cnt0 = '0;
         m_cnt1 = '0;
      end else begin
         check("grant_cnt0", grant_cnt0, m_cnt0);
         check("grant_cnt1", grant_cnt1, m_cnt1);
         m_acc = (q.size() == 0) || rsp_ready;
         m_g0  = req0_valid && (!req1_valid || m_last);
         m_g1  = req1_valid && !m_g0;
         check("req0_ready", req0_ready, m_acc && m_g0);
         check("req1_ready", req1_ready, m_acc && m_g1);
         if (m_acc && m_g0) begin
            q.push_back('{data: ref_shift(int'(req0_data), int'(req0_amt), int'(req0_op)),
                          id: 1'b0, stamp: cycle});
            m_last = 1'b0;
            m_cnt0++;
         end else if (m_acc && m_g1) begin
            q.push_back('{data: ref_shift(int'(req1_data), int'(req1_amt), int'(req1_op)),
                          id: 1'b1, stamp: cycle});
            m_last = 1'b1;
            m_cnt1++;
         end
      end
   end

   // Monitor: whatever the DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (q.size() > 0 && q[0].stamp < cycle) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, q[0].data);
            check("rsp_id", rsp_id, q[0].id);
            if (rsp_ready) void'(q.pop_front());
         end else begin
            check("rsp_valid_idle", rsp_valid, 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string name, input logic [7:0] d, input logic [2:0] a,
                           input shift_op_t op, input logic [7:0] exp);
      req0_valid = 1'b1;
      req0_data  = d;
      req0_amt   = a;
      req0_op    = op;
      rsp_ready  = 1'b1;
      step();
      req0_valid = 1'b0;
      check({name, "_valid"}, rsp_valid, 1);
      check({name, "_data"}, rsp_data, exp);
      check({name, "_id"}, rsp_id, 0);
   endtask

   task automatic rand_req();
      req0_data = 8'($urandom);
      req0_amt  = 3'($urandom);
      req0_op   = shift_op_t'(2'($urandom));
      req1_data = 8'($urandom);
      req1_amt  = 3'($urandom);
      req1_op   = shift_op_t'(2'($urandom));
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int rem;
      logic [7:0] exp_d;
      rst        = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b0;
      rand_req();
      repeat (3) step();
      rst        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_cnt0", grant_cnt0, 0);
      check("reset_cnt1", grant_cnt1, 0);

      directed("sra3", 8'h96, 3'd3, SRA, 8'hF2);
      directed("ror1", 8'h81, 3'd1, ROR, 8'hC0);
      directed("sll1", 8'h81, 3'd1, SLL, 8'h02);
      directed("srl7", 8'h81, 3'd7, SRL, 8'h01);
      directed("srl0", 8'hA5, 3'd0, SRL, 8'hA5);
      directed("sra0", 8'hA5, 3'd0, SRA, 8'hA5);
      directed("sll0", 8'hA5, 3'd0, SLL, 8'hA5);
      directed("ror0", 8'hA5, 3'd0, ROR, 8'hA5);

      // Exhaustive sweep, one command per cycle from requester 0.
      rsp_ready  = 1'b1;
      req0_valid = 1'b1;
      for (int op = 0; op < 4; op++)
         for (int a = 0; a < 8; a++)
            for (int d = 0; d < 256; d++) begin
               req0_op   = shift_op_t'(2'(op));
               req0_amt  = 3'(a);
               req0_data = 8'(d);
               step();
            end
      req0_valid = 1'b0;
      step();

      // Top up requester 0 to exactly 65536 grants: counter must wrap.
      rem = 65536 - int'(m_cnt0);
      req0_valid = 1'b1;
      repeat (rem) begin
         rand_req();
         step();
      end
      req0_valid = 1'b0;
      step();
      check("cnt0_wrap", grant_cnt0, 16'h0000);
      check("cnt1_unchanged", grant_cnt1, 16'h0000);

      rst = 1'b1;
      step();
      rst = 1'b0;

      // Both requesters valid: strict alternation starting at 0.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         rand_req();
         step();
         check("alt_valid", rsp_valid, 1);
         check("alt_id", rsp_id, 32'(k % 2));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      check("alt_cnt0", grant_cnt0, 50);
      check("alt_cnt1", grant_cnt1, 50);
      step();

      // Backpressure: fill, then hold for 5 cycles.
      req0_valid = 1'b1;
      rand_req();
      step();
      rsp_ready  = 1'b0;
      req1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         rand_req();
         step();
         check("bp_ready0", req0_ready, 0);
         check("bp_ready1", req1_ready, 0);
         check("bp_valid", rsp_valid, 1);
         check("bp_data", rsp_data, q[0].data);
         check("bp_id", rsp_id, 0);
      end
      req0_valid = 1'b0;
      rsp_ready  = 1'b1;
      rand_req();
      exp_d = ref_shift(int'(req1_data), int'(req1_amt), int'(req1_op));
      #1;
      check("bp_same_cycle_ready1", req1_ready, 1);
      step();
      req1_valid = 1'b0;
      check("bp_reload_valid", rsp_valid, 1);
      check("bp_reload_id", rsp_id, 1);
      check("bp_reload_data", rsp_data, exp_d);
      step();
      step();

      // Random traffic with random backpressure.
      repeat (3000) begin
         rand_req();
         req0_valid = 1'($urandom);
         req1_valid = 1'($urandom);
         rsp_ready  = ($urandom % 4) != 0;
         step();
      end

      // Reset while full and both requesters valid.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      step();
      rst       = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("post_rst_valid", rsp_valid, 0);
      check("post_rst_cnt0", grant_cnt0, 0);
      check("post_rst_cnt1", grant_cnt1, 0);
      check("post_rst_ready0", req0_ready, 1);
      check("post_rst_ready1", req1_ready, 0);
      step();
      check("post_rst_first_id", rsp_id, 0);
      check("post_rst_first_valid", rsp_valid, 1);

      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (3) step();
      check("queue_drained", 32'(q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
